// File: rtl/lcd_timing_pkg.sv
// ---------------------------------------------------------------------------
// lcd_timing_pkg
// Shared constants and helpers for the parametrised LCD timing controller.
//   - Default 800x480 panel timing values (used as parameter defaults).
//   - lcd_total(): sum of sync/back/active/front values for one axis.
//   - clog2_min1(): ceil(log2(n)) clamped to at least 1 bit.
//   - Colour-bar masks for the optional internal test pattern
//     (enabled by the LCD_TEST_PATTERN_EN macro in the top level).
// ---------------------------------------------------------------------------
package lcd_timing_pkg;

    // Default 800x480 timing
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BACK   = 88;
    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FRONT  = 40;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;

    // Colour-bar masks, bit order {R,G,B}; a set bit means full-scale channel.
    localparam int       BAR_COUNT   = 8;
    localparam logic [2:0] BAR_WHITE   = 3'b111;
    localparam logic [2:0] BAR_YELLOW  = 3'b110;
    localparam logic [2:0] BAR_CYAN    = 3'b011;
    localparam logic [2:0] BAR_GREEN   = 3'b010;
    localparam logic [2:0] BAR_MAGENTA = 3'b101;
    localparam logic [2:0] BAR_RED     = 3'b100;
    localparam logic [2:0] BAR_BLUE    = 3'b001;
    localparam logic [2:0] BAR_BLACK   = 3'b000;

    function automatic int lcd_total(input int sync_w, input int back_w,
                                     input int active_w, input int front_w);
        return sync_w + back_w + active_w + front_w;
    endfunction

    // Counter widths must never collapse to zero bits, even for 1-entry ranges.
    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    // Bar index 0..7 (left to right) to RGB mask.
    function automatic logic [2:0] bar_rgb_mask(input logic [2:0] idx);
        logic [2:0] m;
        m = BAR_BLACK;
        case (idx)
            3'd0:    m = BAR_WHITE;
            3'd1:    m = BAR_YELLOW;
            3'd2:    m = BAR_CYAN;
            3'd3:    m = BAR_GREEN;
            3'd4:    m = BAR_MAGENTA;
            3'd5:    m = BAR_RED;
            3'd6:    m = BAR_BLUE;
            default: m = BAR_BLACK;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lcd_bl_pwm.sv
// ---------------------------------------------------------------------------
// lcd_bl_pwm
// Backlight PWM generator. A prescaler divides clk_in by BL_DIV; each
// prescaler wrap advances an 8-bit PWM counter. The duty value is only
// taken from bl_duty when the PWM counter wraps 255->0, so a duty change
// never produces a truncated or stretched period.
// Ports:
//   clk_in     in   pixel clock
//   sys_rst_n  in   synchronous active-low reset
//   bl_duty    in   8-bit duty (0 = off, 255 = high 255/256)
//   lcd_bl     out  registered PWM output
// ---------------------------------------------------------------------------
module lcd_bl_pwm
    import lcd_timing_pkg::*;
#(
    parameter int BL_DIV = 64
)
(
    input  logic       clk_in,
    input  logic       sys_rst_n,
    input  logic [7:0] bl_duty,
    output logic       lcd_bl
);

    localparam int PRE_W = clog2_min1(BL_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BL_DIV - 1);

    logic [PRE_W-1:0] r_pre;
    logic [7:0]       r_pwm_cnt;
    logic [7:0]       r_duty_q;
    logic             r_bl;
    logic             w_step;

    assign w_step = (r_pre == PRE_LAST);

    always_ff @(posedge clk_in) begin
        if (!sys_rst_n) begin
            r_pre     <= '0;
            r_pwm_cnt <= '0;
            r_duty_q  <= '0;
            r_bl      <= 1'b0;
        end else begin
            if (w_step) begin
                r_pre     <= '0;
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
                // New duty lands exactly at the period boundary.
                if (r_pwm_cnt == 8'hFF) begin
                    r_duty_q <= bl_duty;
                end
            end else begin
                r_pre <= r_pre + PRE_W'(1);
            end
            r_bl <= (r_pwm_cnt < r_duty_q);
        end
    end

    assign lcd_bl = r_bl;

endmodule

// File: rtl/lcd_timing_ctrl_param.sv
// ---------------------------------------------------------------------------
// lcd_timing_ctrl_param
// Parametrised LCD timing controller: hsync/vsync/DE generation, pixel
// requests issued REQ_LEAD cycles ahead of DE, registered RGB output,
// backlight PWM and a frame-start strobe.
// Optional feature macro: LCD_TEST_PATTERN_EN adds input test_en which
// replaces data_in with 8 internal vertical colour bars while high.
// Ports:
//   clk_in       in   pixel clock
//   sys_rst_n    in   synchronous active-low reset
//   data_in      in   upstream pixel, valid REQ_LEAD cycles after request
//   bl_duty      in   backlight duty (0 = off)
//   test_en      in   colour-bar select (LCD_TEST_PATTERN_EN builds only)
//   data_req     out  pixel request strobe (combinational from counters)
//   pix_x/pix_y  out  requested column/row, 0 when data_req is low
//   rgb_lcd      out  registered panel data {R,G,B}
//   hsync/vsync  out  registered syncs, polarity from HS_POL/VS_POL
//   lcd_de       out  registered data enable
//   lcd_clk      out  inverted pixel clock (data launched on clk_in rise
//                     is sampled by the panel on lcd_clk rise)
//   lcd_bl       out  backlight PWM
//   frame_start  out  one-cycle pulse after h_cnt=0, v_cnt=0
// ---------------------------------------------------------------------------
module lcd_timing_ctrl_param
    import lcd_timing_pkg::*;
#(
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int COLOR_W  = 8,
    parameter int REQ_LEAD = 1,
    parameter int BL_DIV   = 64,
    localparam int X_W     = clog2_min1(H_ACTIVE),
    localparam int Y_W     = clog2_min1(V_ACTIVE)
)
(
    input  logic                   clk_in,
    input  logic                   sys_rst_n,
    input  logic [3*COLOR_W-1:0]   data_in,
    input  logic [7:0]             bl_duty,
`ifdef LCD_TEST_PATTERN_EN
    input  logic                   test_en,
`endif
    output logic                   data_req,
    output logic [X_W-1:0]         pix_x,
    output logic [Y_W-1:0]         pix_y,
    output logic [3*COLOR_W-1:0]   rgb_lcd,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   lcd_de,
    output logic                   lcd_clk,
    output logic                   lcd_bl,
    output logic                   frame_start
);

    localparam int H_TOTAL = lcd_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
    localparam int V_TOTAL = lcd_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
    localparam int H_START = H_SYNC + H_BACK;
    localparam int V_START = V_SYNC + V_BACK;
    localparam int HC_W    = clog2_min1(H_TOTAL);
    localparam int VC_W    = clog2_min1(V_TOTAL);
    localparam int RGB_W   = 3 * COLOR_W;

    // Window bounds; all fit the counter width because the front porches
    // are at least one clock/line.
    localparam logic [HC_W-1:0] H_LAST     = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_SYNC_END = HC_W'(H_SYNC);
    localparam logic [HC_W-1:0] REQ_LO     = HC_W'(H_START - REQ_LEAD);
    localparam logic [HC_W-1:0] REQ_HI     = HC_W'(H_START - REQ_LEAD + H_ACTIVE);
    localparam logic [HC_W-1:0] DE_LO      = HC_W'(H_START);
    localparam logic [HC_W-1:0] DE_HI      = HC_W'(H_START + H_ACTIVE);
    localparam logic [VC_W-1:0] V_LAST     = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_SYNC_END = VC_W'(V_SYNC);
    localparam logic [VC_W-1:0] V_LO       = VC_W'(V_START);
    localparam logic [VC_W-1:0] V_HI       = VC_W'(V_START + V_ACTIVE);
    localparam logic            HS_ACT     = (HS_POL != 0);
    localparam logic            VS_ACT     = (VS_POL != 0);

    // Reject unusable configurations at elaboration.
    generate
        if (H_SYNC < 1 || H_BACK < 1 || H_ACTIVE < 1 || H_FRONT < 1 ||
            V_SYNC < 1 || V_BACK < 1 || V_ACTIVE < 1 || V_FRONT < 1 ||
            COLOR_W < 1) begin : g_bad_width
            $error("lcd_timing_ctrl_param: timing widths and COLOR_W must be >= 1");
        end
        if (REQ_LEAD < 1 || REQ_LEAD > H_SYNC + H_BACK - 1) begin : g_bad_lead
            $error("lcd_timing_ctrl_param: REQ_LEAD must be in 1..H_SYNC+H_BACK-1");
        end
        if (BL_DIV < 1) begin : g_bad_div
            $error("lcd_timing_ctrl_param: BL_DIV must be >= 1");
        end
    endgenerate

    logic [HC_W-1:0]  r_h_cnt;
    logic [VC_W-1:0]  r_v_cnt;
    logic             r_de;
    logic [RGB_W-1:0] r_rgb;
    logic             r_hs;
    logic             r_vs;
    logic             r_fs;

    logic             w_v_act;
    logic             w_h_req;
    logic             w_h_de;
    logic             w_req;
    logic             w_de;
    logic [RGB_W-1:0] w_pix_src;

    // Raster counters
    always_ff @(posedge clk_in) begin
        if (!sys_rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VC_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HC_W'(1);
        end
    end

    // Request window is the display window shifted left by REQ_LEAD so the
    // upstream latency is absorbed before the pixel is needed.
    assign w_v_act  = (r_v_cnt >= V_LO)   && (r_v_cnt < V_HI);
    assign w_h_req  = (r_h_cnt >= REQ_LO) && (r_h_cnt < REQ_HI);
    assign w_h_de   = (r_h_cnt >= DE_LO)  && (r_h_cnt < DE_HI);
    assign w_req    = w_v_act && w_h_req;
    assign w_de     = w_v_act && w_h_de;

    assign data_req = w_req;
    assign pix_x    = w_req ? X_W'(r_h_cnt - REQ_LO) : '0;
    assign pix_y    = w_req ? Y_W'(r_v_cnt - V_LO)   : '0;

`ifdef LCD_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / BAR_COUNT < 1) ? 1 : H_ACTIVE / BAR_COUNT;

    logic [X_W-1:0]   w_col;
    logic [2:0]       w_bar_idx;
    logic [2:0]       w_bar_mask;
    logic [RGB_W-1:0] w_bar_pix;

    // Display column; only meaningful while w_de is high.
    assign w_col = X_W'(r_h_cnt - DE_LO);

    // Columns beyond 8*BAR_W (when H_ACTIVE is not a multiple of 8) stay in
    // the last bar.
    always_comb begin
        int idx;
        idx       = int'(w_col) / BAR_W;
        w_bar_idx = (idx > BAR_COUNT - 1) ? 3'(BAR_COUNT - 1) : 3'(idx);
    end

    assign w_bar_mask = bar_rgb_mask(w_bar_idx);

    // Channel gi: 0 = blue (LSBs), 1 = green, 2 = red (MSBs).
    for (genvar gi = 0; gi < 3; gi++) begin : g_bar_chan
        assign w_bar_pix[gi*COLOR_W +: COLOR_W] = {COLOR_W{w_bar_mask[gi]}};
    end

    assign w_pix_src = test_en ? w_bar_pix : data_in;
`else
    assign w_pix_src = data_in;
`endif

    // Panel-side outputs, one cycle behind the counters.
    always_ff @(posedge clk_in) begin
        if (!sys_rst_n) begin
            r_de  <= 1'b0;
            r_rgb <= '0;
            r_hs  <= ~HS_ACT;
            r_vs  <= ~VS_ACT;
            r_fs  <= 1'b0;
        end else begin
            r_de  <= w_de;
            r_rgb <= w_de ? w_pix_src : '0;
            r_hs  <= (r_h_cnt < H_SYNC_END) ? HS_ACT : ~HS_ACT;
            r_vs  <= (r_v_cnt < V_SYNC_END) ? VS_ACT : ~VS_ACT;
            r_fs  <= (r_h_cnt == '0) && (r_v_cnt == '0);
        end
    end

    assign lcd_de      = r_de;
    assign rgb_lcd     = r_rgb;
    assign hsync       = r_hs;
    assign vsync       = r_vs;
    assign frame_start = r_fs;
    assign lcd_clk     = ~clk_in;

    lcd_bl_pwm #(
        .BL_DIV (BL_DIV)
    ) u_bl_pwm (
        .clk_in    (clk_in),
        .sys_rst_n (sys_rst_n),
        .bl_duty   (bl_duty),
        .lcd_bl    (lcd_bl)
    );

endmodule

// File: tb/tb_lcd_timing_ctrl_param.sv
// ---------------------------------------------------------------------------
// tb_lcd_timing_ctrl_param
// Two controller instances on a small 15x8 raster (H 2/3/8/2, V 1/2/4/1):
//   u0: REQ_LEAD=1, HS_POL=1, VS_POL=0, COLOR_W=8, BL_DIV=1
//   u1: REQ_LEAD=3, HS_POL=0, VS_POL=1, COLOR_W=5, BL_DIV=3
// Each instance has an upstream pixel source with REQ_LEAD cycles of
// latency reading a random frame image, and a reference model that derives
// raster position from the number of cycles since reset.
// ---------------------------------------------------------------------------
module tb_lcd_timing_ctrl_param;

    localparam int NCYC = 6000;

    localparam int P_LEAD [2] = '{1, 3};
    localparam int P_HPOL [2] = '{1, 0};
    localparam int P_VPOL [2] = '{0, 1};
    localparam int P_CW   [2] = '{8, 5};
    localparam int P_BLD  [2] = '{1, 3};

    localparam int HS = 2, HB = 3, HA = 8, HF = 2;
    localparam int VS = 1, VB = 2, VA = 4, VF = 1;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int HST = HS + HB;
    localparam int VST = VS + VB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] duty [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task automatic check_eq(input int inst, input string tag,
                            input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL u%0d %s got=0x%0h exp=0x%0h", inst, tag, got, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int L   = P_LEAD[gi];
        localparam int CW  = P_CW[gi];
        localparam int RW  = 3 * CW;
        localparam int BLD = P_BLD[gi];
        localparam int XW  = $clog2(HA);
        localparam int YW  = $clog2(VA);
        localparam logic HPL = (P_HPOL[gi] != 0);
        localparam logic VPL = (P_VPOL[gi] != 0);

        logic          data_req;
        logic [XW-1:0] pix_x;
        logic [YW-1:0] pix_y;
        logic [RW-1:0] rgb_lcd;
        logic [RW-1:0] data_in;
        logic hsync, vsync, lcd_de, lcd_clk, lcd_bl, frame_start;

        lcd_timing_ctrl_param #(
            .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
            .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
            .HS_POL(P_HPOL[gi]), .VS_POL(P_VPOL[gi]), .COLOR_W(CW),
            .REQ_LEAD(L), .BL_DIV(BLD)
        ) dut (
            .clk_in      (clk),
            .sys_rst_n   (rst_n),
            .data_in     (data_in),
            .bl_duty     (duty[gi]),
`ifdef LCD_TEST_PATTERN_EN
            .test_en     (1'b0),
`endif
            .data_req    (data_req),
            .pix_x       (pix_x),
            .pix_y       (pix_y),
            .rgb_lcd     (rgb_lcd),
            .hsync       (hsync),
            .vsync       (vsync),
            .lcd_de      (lcd_de),
            .lcd_clk     (lcd_clk),
            .lcd_bl      (lcd_bl),
            .frame_start (frame_start)
        );

        // Random frame image and an upstream source with L cycles latency;
        // outside requests it emits garbage that must never reach the panel.
        logic [RW-1:0] img [VA][HA];
        logic [RW-1:0] up_pipe [L];

        initial begin
            for (int y = 0; y < VA; y++)
                for (int x = 0; x < HA; x++)
                    img[y][x] = RW'($urandom);
        end

        always @(posedge clk) begin
            up_pipe[0] <= data_req ? img[pix_y][pix_x] : RW'($urandom);
            for (int i = 1; i < L; i++) up_pipe[i] <= up_pipe[i-1];
        end
        assign data_in = up_pipe[L-1];

        // Reference model: m_t = cycles since reset release.
        int            m_t = 0;
        int            m_duty = 0;
        bit            m_valid = 1'b0;
        logic          e_de, e_hs, e_vs, e_fs, e_bl;
        logic [RW-1:0] e_rgb;

        always @(posedge clk) begin : model
            int  h, v;
            bit  de;
            h  = m_t % HT;
            v  = (m_t / HT) % VT;
            de = (v >= VST) && (v < VST + VA) && (h >= HST) && (h < HST + HA);
            if (!rst_n) begin
                m_t     <= 0;
                m_duty  <= 0;
                m_valid <= 1'b1;
                e_de    <= 1'b0;
                e_rgb   <= '0;
                e_hs    <= ~HPL;
                e_vs    <= ~VPL;
                e_fs    <= 1'b0;
                e_bl    <= 1'b0;
            end else begin
                e_de  <= de;
                e_rgb <= de ? img[v - VST][h - HST] : '0;
                e_hs  <= (h < HS) ? HPL : ~HPL;
                e_vs  <= (v < VS) ? VPL : ~VPL;
                e_fs  <= (h == 0) && (v == 0);
                e_bl  <= (((m_t / BLD) % 256) < m_duty);
                if (((m_t + 1) % (256 * BLD)) == 0) m_duty <= int'(duty[gi]);
                m_t   <= m_t + 1;
            end
        end

        always @(negedge clk) begin : chk
            int h, v, px, py;
            bit req;
            if (m_valid) begin
                h   = m_t % HT;
                v   = (m_t / HT) % VT;
                req = (v >= VST) && (v < VST + VA) &&
                      (h >= HST - L) && (h < HST - L + HA);
                px  = req ? h - (HST - L) : 0;
                py  = req ? v - VST : 0;
                check_eq(gi, "data_req",    32'(data_req),    32'(req));
                check_eq(gi, "pix_x",       32'(pix_x),       32'(px));
                check_eq(gi, "pix_y",       32'(pix_y),       32'(py));
                check_eq(gi, "lcd_de",      32'(lcd_de),      32'(e_de));
                check_eq(gi, "rgb_lcd",     32'(rgb_lcd),     32'(e_rgb));
                check_eq(gi, "hsync",       32'(hsync),       32'(e_hs));
                check_eq(gi, "vsync",       32'(vsync),       32'(e_vs));
                check_eq(gi, "frame_start", 32'(frame_start), 32'(e_fs));
                check_eq(gi, "lcd_bl",      32'(lcd_bl),      32'(e_bl));
                check_eq(gi, "lcd_clk",     32'(lcd_clk),     32'(1'b1));
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        duty[0] = 8'd64;
        duty[1] = 8'd128;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        $display("reset released duty0=%0d duty1=%0d", duty[0], duty[1]);
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            rst_n = 1'b1;
            // Directed: one-cycle reset in the middle of an active line.
            if (cyc == 426 || (cyc > 1000 && $urandom_range(0, 999) == 0)) begin
                rst_n = 1'b0;
                $display("cycle %0d: reset pulse", cyc);
            end
            // Directed duty changes for u0: mid-period drop to 0, then 255.
            if (cyc == 700) begin
                duty[0] = 8'd0;
                $display("cycle %0d: duty0 -> 0", cyc);
            end
            if (cyc == 1500) begin
                duty[0] = 8'd255;
                $display("cycle %0d: duty0 -> 255", cyc);
            end
            if (cyc > 2200 && $urandom_range(0, 299) == 0) begin
                for (int i = 0; i < 2; i++) begin
                    case ($urandom_range(0, 3))
                        0:       duty[i] = 8'd0;
                        1:       duty[i] = 8'd255;
                        default: duty[i] = 8'($urandom);
                    endcase
                end
                $display("cycle %0d: duty0=%0d duty1=%0d", cyc, duty[0], duty[1]);
            end
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
